sp_mem_arbiter: RTL and testbench



---
 rtl/sp_pkg.sv | 19 +
 rtl/sp_rr_arb2.sv | 38 +++
 rtl/sp_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_sp_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_pkg.sv
// Shared constants and types for the shortest-path engine memory subsystem.
package sp_pkg;

    localparam int D_WIDTH  = 8;
    localparam int A_WIDTH  = 13;
    localparam int MAX      = 8192;
    localparam int SIZE_ROW = 64;

    // Path-direction codes written into the grid by the engine.
    localparam logic [D_WIDTH-1:0] P_START = 8'h08;
    localparam logic [D_WIDTH-1:0] P_RIGHT = 8'h09;
    localparam logic [D_WIDTH-1:0] P_DOWN  = 8'h0A;

    typedef struct packed {
        logic vld;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/sp_rr_arb2.sv
// Two-requester arbiter: round-robin or fixed priority to requester 1.
module sp_rr_arb2 #(
    parameter int PRIO_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr_q = 0 prefers requester 0, 1 prefers requester 1.
    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (PRIO_MODE != 0 || ptr_q) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        if (gnt[0])
            ptr_d = 1'b1;
        else if (gnt[1])
            ptr_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= 1'b0;
        else
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sp_mem_arbiter.sv
// Shares one single-port SRAM between the host and the shortest-path engine;
// registered command path plus an owner-tag pipeline that steers read data back.
module sp_mem_arbiter
    import sp_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int RD_LAT    = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Req0,
    input  logic               Req1,
    input  logic               Rw0,
    input  logic               Rw1,
    input  logic [A_WIDTH-1:0] Addr0,
    input  logic [A_WIDTH-1:0] Addr1,
    input  logic [D_WIDTH-1:0] Wdata0,
    input  logic [D_WIDTH-1:0] Wdata1,
    output logic               Gnt0,
    output logic               Gnt1,
    output logic [D_WIDTH-1:0] Rdata0,
    output logic [D_WIDTH-1:0] Rdata1,
    output logic               Rvalid0,
    output logic               Rvalid1,
    output logic               Mem_En,
    output logic               Mem_Rw,
    output logic [A_WIDTH-1:0] Mem_Addr,
    output logic [D_WIDTH-1:0] Mem_Out,
    input  logic [D_WIDTH-1:0] Mem_In
);

    logic [1:0] gnt;

    sp_rr_arb2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
        .clk (Clk),
        .rst (Rst),
        .req ({Req1, Req0}),
        .gnt (gnt)
    );

    assign Gnt0 = gnt[0];
    assign Gnt1 = gnt[1];

    logic               mem_en_q,   mem_en_d;
    logic               mem_rw_q,   mem_rw_d;
    logic [A_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [D_WIDTH-1:0] mem_out_q,  mem_out_d;
    logic [D_WIDTH-1:0] rdata0_q,   rdata0_d;
    logic [D_WIDTH-1:0] rdata1_q,   rdata1_d;
    logic               rvalid0_q,  rvalid0_d;
    logic               rvalid1_q,  rvalid1_d;
    rd_tag_t [RD_LAT-1:0] tag_q, tag_d;
    rd_tag_t            tag_tail;

    assign tag_tail = tag_q[RD_LAT-1];

    always_comb begin
        mem_en_d   = 1'b0;
        mem_rw_d   = 1'b0;
        mem_addr_d = '0;
        mem_out_d  = '0;
        if (gnt[0]) begin
            mem_en_d   = 1'b1;
            mem_rw_d   = Rw0;
            mem_addr_d = Addr0;
            mem_out_d  = Rw0 ? Wdata0 : '0;
        end else if (gnt[1]) begin
            mem_en_d   = 1'b1;
            mem_rw_d   = Rw1;
            mem_addr_d = Addr1;
            mem_out_d  = Rw1 ? Wdata1 : '0;
        end

        // Only reads enter the tag pipe; writes travel as empty slots.
        tag_d          = '0;
        tag_d[0].vld   = mem_en_d & ~mem_rw_d;
        tag_d[0].owner = gnt[1];
        for (int i = 1; i < RD_LAT; i++)
            tag_d[i] = tag_q[i-1];

        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = tag_tail.vld & ~tag_tail.owner;
        rvalid1_d = tag_tail.vld &  tag_tail.owner;
        if (rvalid0_d)
            rdata0_d = Mem_In;
        if (rvalid1_d)
            rdata1_d = Mem_In;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_out_q  <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            tag_q      <= '0;
        end else begin
            mem_en_q   <= mem_en_d;
            mem_rw_q   <= mem_rw_d;
            mem_addr_q <= mem_addr_d;
            mem_out_q  <= mem_out_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            tag_q      <= tag_d;
        end
    end

    assign Mem_En   = mem_en_q;
    assign Mem_Rw   = mem_rw_q;
    assign Mem_Addr = mem_addr_q;
    assign Mem_Out  = mem_out_q;
    assign Rdata0   = rdata0_q;
    assign Rdata1   = rdata1_q;
    assign Rvalid0  = rvalid0_q;
    assign Rvalid1  = rvalid1_q;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Randomized + directed bench for sp_mem_arbiter against a transaction-level model.
module tb_sp_mem_arbiter;

    localparam int RD_LAT = 2;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Req0 = 1'b0, Req1 = 1'b0, Rw0 = 1'b0, Rw1 = 1'b0;
    logic [12:0] Addr0 = '0, Addr1 = '0;
    logic [7:0]  Wdata0 = '0, Wdata1 = '0;
    logic        Gnt0, Gnt1, Rvalid0, Rvalid1, Mem_En, Mem_Rw;
    logic [7:0]  Rdata0, Rdata1, Mem_Out;
    logic [12:0] Mem_Addr;
    logic [7:0]  Mem_In = 8'h00;

    logic        p_gnt0, p_gnt1, p_rv0, p_rv1, p_mem_en, p_mem_rw;
    logic [7:0]  p_rd0, p_rd1, p_mem_out;
    logic [12:0] p_mem_addr;

    always #5 Clk = ~Clk;

    sp_mem_arbiter #(.PRIO_MODE(0), .RD_LAT(RD_LAT)) dut (
        .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1), .Rw0(Rw0), .Rw1(Rw1),
        .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .Rdata0(Rdata0), .Rdata1(Rdata1),
        .Rvalid0(Rvalid0), .Rvalid1(Rvalid1), .Mem_En(Mem_En), .Mem_Rw(Mem_Rw),
        .Mem_Addr(Mem_Addr), .Mem_Out(Mem_Out), .Mem_In(Mem_In)
    );

    sp_mem_arbiter #(.PRIO_MODE(1), .RD_LAT(RD_LAT)) dut_p (
        .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1), .Rw0(Rw0), .Rw1(Rw1),
        .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
        .Gnt0(p_gnt0), .Gnt1(p_gnt1), .Rdata0(p_rd0), .Rdata1(p_rd1),
        .Rvalid0(p_rv0), .Rvalid1(p_rv1), .Mem_En(p_mem_en), .Mem_Rw(p_mem_rw),
        .Mem_Addr(p_mem_addr), .Mem_Out(p_mem_out), .Mem_In(Mem_In)
    );

    function automatic logic [7:0] init_val(input int a);
        case (a)
            1:       return 8'h11;
            2:       return 8'h22;
            3:       return 8'h33;
            5:       return 8'h33;
            default: return 8'(a) ^ 8'h5A;
        endcase
    endfunction

    // SRAM device: command seen in one cycle, read data presented the next.
    logic [7:0] sram   [0:8191];
    bit         sram_w [0:8191];
    always @(posedge Clk) begin
        if (Mem_En) begin
            if (Mem_Rw) begin
                sram[Mem_Addr]   <= Mem_Out;
                sram_w[Mem_Addr] <= 1'b1;
            end else begin
                Mem_In <= sram_w[Mem_Addr] ? sram[Mem_Addr] : init_val(int'(Mem_Addr));
            end
        end
    end

    int total = 0, bad = 0, cyc = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", tag, cyc, act, exp);
        end
    endtask

    // Reference model: memory image, who won last, expected returns by cycle.
    typedef struct { int cyc; bit own; logic [7:0] d; } ret_t;
    ret_t        rq[$];
    logic [7:0]  ref_mem [0:8191];
    int          last_gnt;
    logic [22:0] exp_bus;
    logic        exp_pen;
    logic [7:0]  exp_rd0, exp_rd1;
    logic        g0, g1;

    task automatic model_rst();
        rq.delete();
        last_gnt = 1;
        exp_bus  = '0;
        exp_pen  = 1'b0;
        exp_rd0  = '0;
        exp_rd1  = '0;
    endtask

    task automatic cyc_step();
        logic eg0, eg1, ev0, ev1, rw;
        logic [12:0] a;
        logic [7:0] wd;
        ret_t r;
        @(negedge Clk);
        eg0 = Req0;
        eg1 = Req1;
        if (Req0 && Req1) begin
            eg0 = (last_gnt == 1);
            eg1 = (last_gnt == 0);
        end
        chk("gnt", {Gnt1, Gnt0}, {eg1, eg0});
        chk("prio_gnt", {p_gnt1, p_gnt0}, {Req1, Req0 & ~Req1});
        chk("mem_cmd", {Mem_En, Mem_Rw, Mem_Addr, Mem_Out}, exp_bus);
        chk("prio_mem_en", p_mem_en, exp_pen);
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            r = rq.pop_front();
            if (r.own) begin ev1 = 1'b1; exp_rd1 = r.d; end
            else       begin ev0 = 1'b1; exp_rd0 = r.d; end
        end
        chk("ret0", {Rvalid0, Rdata0}, {ev0, exp_rd0});
        chk("ret1", {Rvalid1, Rdata1}, {ev1, exp_rd1});

        exp_bus = '0;
        if (eg0 || eg1) begin
            rw = eg0 ? Rw0 : Rw1;
            a  = eg0 ? Addr0 : Addr1;
            wd = eg0 ? Wdata0 : Wdata1;
            if (rw) begin
                ref_mem[a] = wd;
                exp_bus = {1'b1, 1'b1, a, wd};
            end else begin
                exp_bus = {1'b1, 1'b0, a, 8'h00};
                rq.push_back('{cyc + RD_LAT + 1, eg1, ref_mem[a]});
            end
            last_gnt = eg1 ? 1 : 0;
        end
        exp_pen = Req0 | Req1;
        g0 = eg0;
        g1 = eg1;
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic set0(input logic rw, input int a, input logic [7:0] d);
        Req0 = 1'b1; Rw0 = rw; Addr0 = 13'(a); Wdata0 = d;
    endtask

    task automatic set1(input logic rw, input int a, input logic [7:0] d);
        Req1 = 1'b1; Rw1 = rw; Addr1 = 13'(a); Wdata1 = d;
    endtask

    task automatic idle(input int n);
        Req0 = 1'b0;
        Req1 = 1'b0;
        repeat (n) cyc_step();
    endtask

    function automatic int rand_addr();
        return ($urandom_range(0, 7) == 0) ? 8191 : int'($urandom_range(0, 15));
    endfunction

    initial begin
        for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
        model_rst();

        // Reset state, with requests pending to prove grants are masked.
        Req0 = 1'b1; Req1 = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_state", {Mem_En, Mem_Rw, Mem_Addr, Mem_Out, Rdata0, Rdata1,
                          Rvalid0, Rvalid1, Gnt0, Gnt1, p_gnt0, p_gnt1}, '0);
        Rst = 1'b0; Req0 = 1'b0; Req1 = 1'b0;

        // Lone engine read of addr 5.
        set1(1'b0, 5, 8'h00);
        cyc_step();
        idle(4);
        chk("rd5_data", Rdata1, 8'h33);

        // Both held 6 cycles: alternating grants, Mem_En every cycle.
        set0(1'b0, 7, 8'h00);
        set1(1'b0, 9, 8'h00);
        for (int i = 0; i < 6; i++) begin
            cyc_step();
            chk("alt_order", {g1, g0}, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        idle(4);

        // Fixed-priority instance: both for 4 cycles, then Req1 drops.
        set0(1'b0, 4, 8'h00);
        set1(1'b0, 6, 8'h00);
        repeat (4) cyc_step();
        Req1 = 1'b0;
        cyc_step();
        idle(4);

        // Host write then engine read of the same address.
        set0(1'b1, 100, 8'hA5);
        cyc_step();
        Req0 = 1'b0;
        set1(1'b0, 100, 8'h00);
        cyc_step();
        idle(4);
        chk("raw_data", Rdata1, 8'hA5);

        // Interleaved reads return in grant order on consecutive cycles.
        set0(1'b0, 1, 8'h00);
        cyc_step();
        Req0 = 1'b0;
        set1(1'b0, 2, 8'h00);
        cyc_step();
        Req1 = 1'b0;
        set0(1'b0, 3, 8'h00);
        cyc_step();
        idle(4);

        // Random traffic; each requester holds its command until granted.
        for (int n = 0; n < 400; n++) begin
            if (!Req0 && $urandom_range(0, 3) != 0)
                set0(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            if (!Req1 && $urandom_range(0, 3) != 0)
                set1(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            cyc_step();
            if (g0) Req0 = 1'b0;
            if (g1) Req1 = 1'b0;
        end
        idle(5);

        // Asynchronous reset one cycle after a read grant drops that read.
        set1(1'b0, 5, 8'h00);
        cyc_step();
        Req1 = 1'b0;
        Req0 = 1'b1;
        #2;
        Rst = 1'b1;
        #1;
        chk("async_rst", {Mem_En, Mem_Rw, Mem_Addr, Mem_Out, Rdata0, Rdata1,
                          Rvalid0, Rvalid1, Gnt0, Gnt1, p_gnt0, p_gnt1}, '0);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        Req0 = 1'b0;
        model_rst();
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
